// File: rtl/sfu_relu_wb.sv
// sfu_relu_wb: write-back stage behind the SFU accumulator.
// Counts accumulate strobes, captures the SFU psum once a group is complete,
// applies ReLU + unsigned saturation and hands the result to the output SRAM
// writer over valid/ready with an auto-incrementing address.
// Optional build macro: SFU_RELU_BYPASS_EN adds relu_en; when relu_en=0 the
// psum is signed-saturated into out_bw bits instead of ReLU'd.
module sfu_relu_wb #(
    parameter int psum_bw = 16,
    parameter int out_bw  = 16,
    parameter int cnt_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [cnt_bw-1:0]         acc_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [psum_bw-1:0] acc_in,
`ifdef SFU_RELU_BYPASS_EN
    input  logic                      relu_en,
`endif
    output logic                      acc_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [out_bw-1:0]         out_data,
    output logic [addr_bw-1:0]        out_addr,
    output logic                      proto_err
);

    typedef enum logic [1:0] {
        S_ACC     = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    logic [cnt_bw-1:0]   r_count;
    logic [cnt_bw-1:0]   r_len;
    logic                r_out_valid;
    logic [out_bw-1:0]   r_out_data;
    logic [addr_bw-1:0]  r_out_addr;
    logic                r_proto_err;

    logic [cnt_bw-1:0]   w_len_new;
    logic [cnt_bw-1:0]   w_len_cur;
    logic                w_last;
    logic                w_neg;
    logic [out_bw-1:0]   w_relu;
    logic [out_bw-1:0]   w_result;

    // Group length: 0 means 1; the live acc_len only matters on the first
    // strobe of a group, afterwards the latched copy is used.
    assign w_len_new = (acc_len == '0) ? cnt_bw'(1) : acc_len;
    assign w_len_cur = (r_count == '0) ? w_len_new : r_len;
    assign w_last    = (r_count == (w_len_cur - cnt_bw'(1)));

    assign w_neg = acc_in[psum_bw-1];

    // ReLU with unsigned clamp to 2^out_bw-1. The sign bit is included in
    // the overflow slice for simplicity; negatives are handled first anyway.
    generate
        if (out_bw < psum_bw) begin : g_relu_sat
            logic w_ovf;
            assign w_ovf  = |acc_in[psum_bw-1:out_bw];
            assign w_relu = w_neg ? '0 : (w_ovf ? '1 : acc_in[out_bw-1:0]);
        end else begin : g_relu_pass
            assign w_relu = w_neg ? '0 : acc_in[out_bw-1:0];
        end
    endgenerate

`ifdef SFU_RELU_BYPASS_EN
    logic [out_bw-1:0] w_ssat;

    // Signed clamp into [-2^(out_bw-1), 2^(out_bw-1)-1]: the value fits when
    // every bit from out_bw-1 upward equals the sign.
    generate
        if (out_bw < psum_bw) begin : g_ssat
            logic [psum_bw-out_bw:0] w_top;
            logic                    w_fit;
            assign w_top  = acc_in[psum_bw-1:out_bw-1];
            assign w_fit  = (&w_top) | ~(|w_top);
            assign w_ssat = w_fit ? acc_in[out_bw-1:0]
                          : (w_neg ? {1'b1, {(out_bw-1){1'b0}}}
                                   : {1'b0, {(out_bw-1){1'b1}}});
        end else begin : g_ssat_pass
            assign w_ssat = acc_in[out_bw-1:0];
        end
    endgenerate

    assign w_result = relu_en ? w_relu : w_ssat;
`else
    assign w_result = w_relu;
`endif

    // Control FSM: count strobes, capture one cycle after the last strobe,
    // hold the result until the writer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACC;
            r_count     <= '0;
            r_len       <= cnt_bw'(1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (in_valid && (r_state != S_ACC))
                r_proto_err <= 1'b1;
            case (r_state)
                S_ACC: begin
                    if (in_valid) begin
                        if (r_count == '0)
                            r_len <= w_len_new;
                        if (w_last) begin
                            r_count <= '0;
                            r_state <= S_CAPTURE;
                        end else begin
                            r_count <= r_count + cnt_bw'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    // acc_in already includes the final term here
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_addr  <= r_out_addr + addr_bw'(1);
                        r_state     <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACC);
    assign acc_clr   = (r_state == S_CAPTURE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_sfu_relu_wb.sv
// Directed bench for sfu_relu_wb. Two instances share the stimulus:
// dut_a uses default widths (out_bw == psum_bw, 11-bit address),
// dut_b uses out_bw=8, addr_bw=2 to reach saturation and address wrap.
module tb_sfu_relu_wb;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         acc_len = 8'd1;
    logic               in_valid = 1'b0;
    logic signed [15:0] acc_in = '0;
    logic               out_ready = 1'b0;
`ifdef SFU_RELU_BYPASS_EN
    logic               relu_en = 1'b1;
`endif

    logic        oa_in_ready, oa_clr, oa_valid, oa_perr;
    logic [15:0] oa_data;
    logic [10:0] oa_addr;
    logic        ob_in_ready, ob_clr, ob_valid, ob_perr;
    logic [7:0]  ob_data;
    logic [1:0]  ob_addr;

    int n_chk = 0;
    int n_err = 0;
    int exp_addr = 0;

    always #5 clk = ~clk;

    sfu_relu_wb dut_a (
        .clk(clk), .rst(rst), .acc_len(acc_len), .in_valid(in_valid),
        .in_ready(oa_in_ready), .acc_in(acc_in),
`ifdef SFU_RELU_BYPASS_EN
        .relu_en(relu_en),
`endif
        .acc_clr(oa_clr), .out_valid(oa_valid), .out_ready(out_ready),
        .out_data(oa_data), .out_addr(oa_addr), .proto_err(oa_perr)
    );

    sfu_relu_wb #(.psum_bw(16), .out_bw(8), .cnt_bw(8), .addr_bw(2)) dut_b (
        .clk(clk), .rst(rst), .acc_len(acc_len), .in_valid(in_valid),
        .in_ready(ob_in_ready), .acc_in(acc_in),
`ifdef SFU_RELU_BYPASS_EN
        .relu_en(relu_en),
`endif
        .acc_clr(ob_clr), .out_valid(ob_valid), .out_ready(out_ready),
        .out_data(ob_data), .out_addr(ob_addr), .proto_err(ob_perr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n strobes with acc_len=len, final SFU value fin visible during CAPTURE;
    // returns in HOLD.
    task automatic run_group(input logic [7:0] len, input int n, input logic signed [15:0] fin);
        acc_len  = len;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            acc_in = 16'(i * 3);
            tick();
        end
        in_valid = 1'b0;
        acc_in   = fin;
        chk("capt_clr", oa_clr, 1);
        chk("capt_rdy", oa_in_ready, 0);
        chk("capt_vld", oa_valid, 0);
        tick();
        chk("clr_done", oa_clr, 0);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ea, input logic [31:0] eb);
        chk({tag, "_vld_a"}, oa_valid, 1);
        chk({tag, "_vld_b"}, ob_valid, 1);
        chk({tag, "_dat_a"}, oa_data, ea);
        chk({tag, "_dat_b"}, ob_data, eb);
        chk({tag, "_adr_a"}, oa_addr, 32'(exp_addr % 2048));
        chk({tag, "_adr_b"}, ob_addr, 32'(exp_addr % 4));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_addr++;
        chk("hs_vld", oa_valid, 0);
        chk("hs_rdy", oa_in_ready, 1);
        chk("hs_adr_a", oa_addr, 32'(exp_addr % 2048));
        chk("hs_adr_b", ob_addr, 32'(exp_addr % 4));
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_vld", oa_valid, 0);
        chk("rst_dat", oa_data, 0);
        chk("rst_adr", oa_addr, 0);
        chk("rst_clr", oa_clr, 0);
        chk("rst_perr", oa_perr, 0);
        chk("rst_rdy", oa_in_ready, 1);
        rst = 1'b0;

        // acc_len=3, psums 5,12,20: output 2 cycles after the last strobe
        acc_len   = 8'd3;
        in_valid  = 1'b1;
        acc_in    = 16'sd0;
        tick();
        acc_in    = 16'sd5;
        tick();
        acc_in    = 16'sd12;
        tick();
        in_valid  = 1'b0;
        acc_in    = 16'sd20;
        chk("t1_clr", oa_clr, 1);
        chk("t1_capt_vld", oa_valid, 0);
        tick();
        chk("t1_clr_once", oa_clr, 0);
        expect_out("t1", 20, 20);
        handshake();

        // ReLU / unsigned saturation
        run_group(8'd2, 2, -16'sd7);
        expect_out("neg7", 0, 0);
        handshake();
        run_group(8'd2, 2, 16'sd1000);
        expect_out("p1000", 1000, 255);
        handshake();
        run_group(8'd1, 1, 16'sd255);
        expect_out("p255", 255, 255);
        handshake();
        run_group(8'd1, 1, 16'sd0);
        expect_out("p0", 0, 0);
        handshake();
        run_group(8'd1, 1, 16'sd256);
        expect_out("p256", 256, 255);
        handshake();

`ifdef SFU_RELU_BYPASS_EN
        // signed saturation path
        relu_en = 1'b0;
        run_group(8'd2, 2, -16'sd7);
        expect_out("byp_n7", 32'hFFF9, 32'hF9);
        handshake();
        run_group(8'd1, 1, 16'sd300);
        expect_out("byp_300", 300, 32'h7F);
        handshake();
        run_group(8'd1, 1, -16'sd300);
        expect_out("byp_n300", 32'hFED4, 32'h80);
        handshake();
        relu_en = 1'b1;
`endif

        // backpressure in HOLD with illegal strobes
        run_group(8'd2, 2, 16'sd42);
        expect_out("hold", 42, 42);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_dat", oa_data, 42);
            chk("hold_adr", oa_addr, 32'(exp_addr % 2048));
            chk("hold_rdy", oa_in_ready, 0);
            chk("hold_vld", oa_valid, 1);
        end
        in_valid = 1'b0;
        chk("perr_a", oa_perr, 1);
        chk("perr_b", ob_perr, 1);
        handshake();
        // count must still be 0: acc_len=2 needs exactly two strobes
        acc_len  = 8'd2;
        in_valid = 1'b1;
        tick();
        chk("cnt_keep1", oa_in_ready, 1);
        tick();
        chk("cnt_keep2", oa_in_ready, 0);
        in_valid = 1'b0;
        acc_in   = 16'sd9;
        tick();
        expect_out("after_hold", 9, 9);
        handshake();

        // reset during HOLD
        run_group(8'd1, 1, 16'sd77);
        expect_out("pre_rst", 77, 77);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        exp_addr = 0;
        chk("rh_vld", oa_valid, 0);
        chk("rh_adr", oa_addr, 0);
        chk("rh_rdy", oa_in_ready, 1);
        chk("rh_perr", oa_perr, 0);

        // reset after 2 of 4 strobes (rst wins over a concurrent strobe)
        acc_len  = 8'd4;
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("ra_vld", oa_valid, 0);
        chk("ra_adr", oa_addr, 0);
        chk("ra_rdy", oa_in_ready, 1);
        chk("ra_perr", oa_perr, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ra_grp_rdy", oa_in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
        acc_in   = 16'sd50;
        chk("ra_clr", oa_clr, 1);
        tick();
        expect_out("ra_out", 50, 50);
        handshake();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ra_no_extra", oa_valid, 0);
        end

        // acc_len=0 treated as 1; 2-bit address wraps 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_addr = 0;
        for (int k = 0; k < 5; k++) begin
            run_group(8'd0, 1, 16'(k + 1));
            expect_out("wrap", 32'(k + 1), 32'(k + 1));
            handshake();
        end
        chk("wrap_end_b", ob_addr, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sfu_relu_wb.md
Name: sfu_relu_wb

Overview:
- Downstream stage of the SFU accumulator.
- Counts the SFU's accumulate strobes; once a configured number of partial sums has been summed, captures the SFU's registered psum.
- Applies ReLU and saturation, then presents the result with an auto-incrementing write address over a valid/ready handshake to the output SRAM writer.
- Backpressures upstream while a result is pending, and pulses a clear request toward the SFU.

Parameters:
- psum_bw, 16, width of the SFU psum (signed).
- out_bw, 16, width of the written result; must satisfy out_bw <= psum_bw.
- cnt_bw, 8, width of the accumulation-length counter.
- addr_bw, 11, width of the output write address.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- acc_len  input  cnt_bw  accumulations per output; 0 is treated as 1; sampled only in ACC when count==0.
- in_valid  input  1  same strobe that drives the SFU in_valid; one accumulate per high cycle.
- in_ready  output  1  high only in ACC; upstream must not raise in_valid when low.
- acc_in  input  psum_bw  signed psum from SFU output.
- acc_clr  output  1  one-cycle pulse in CAPTURE; SFU clear request.
- out_valid  output  1  result available.
- out_ready  input  1  writer accepts.
- out_data  output  out_bw  processed result.
- out_addr  output  addr_bw  write address for out_data.
- proto_err  output  1  sticky: in_valid seen while in_ready low.

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-accumulation or mid-handshake):
  - state=ACC, count=0, out_valid=0, out_data=0, out_addr=0, acc_clr=0, proto_err=0.
- FSM states: ACC, CAPTURE, HOLD.
- ACC:
  - in_ready=1.
  - Each in_valid cycle increments count.
  - When in_valid && count==L-1 (L=max(acc_len,1)): count<=0 and next state CAPTURE.
  - acc_len is latched into L at the first in_valid of a group; later changes do not affect the current group.
- CAPTURE (exactly 1 cycle):
  - in_ready=0, acc_clr=1.
  - acc_in now holds the SFU's value including the final term, since the SFU registers one cycle after in_valid.
  - out_data<=f(acc_in), out_valid<=1, next state HOLD.
- HOLD:
  - in_ready=0, out_valid=1; out_data and out_addr are stable.
  - On out_valid&&out_ready: out_valid<=0, out_addr<=out_addr+1 (wraps 2^addr_bw-1 -> 0), next state ACC.
- Latency:
  - Final in_valid at cycle t: CAPTURE at t+1, out_valid high from t+2.
  - With out_ready held high, handshake completes at t+2 and in_ready returns at t+3.
- out_ready asserted while out_valid=0 has no effect.
- Transform f:
  - x<0 -> 0.
  - 0 <= x <= 2^out_bw-1 -> x (zero-extended or truncated without loss).
  - x > 2^out_bw-1 -> 2^out_bw-1. Saturation is reachable only when out_bw < psum_bw-1.
- in_valid while in_ready=0:
  - Ignored: no count change, no state change.
  - proto_err<=1, cleared only by rst.
- Simultaneous rst and any other event: rst wins.

Optional Feature:
- Macro: SFU_RELU_BYPASS_EN.
- When defined:
  - Adds input port relu_en (1 bit), sampled in CAPTURE.
  - relu_en=1 -> f as above.
  - relu_en=0 -> signed saturation of acc_in into out_bw bits: clamp to [-2^(out_bw-1), 2^(out_bw-1)-1]; pass-through when out_bw==psum_bw.
- When undefined: no relu_en port; ReLU is always applied.

Test Plan:
- acc_len=3; in_valid for 3 cycles with SFU psum sequence 5, 12, 20; out_ready=1 -> out_valid high 2 cycles after the third strobe, out_data=20, out_addr=0, acc_clr pulses once, then out_addr=1.
- acc_len=2; final psum=-7 -> out_data=0. Define SFU_RELU_BYPASS_EN with relu_en=0 and out_bw=8: psum=-7 -> out_data=8'hF9; psum=300 -> 8'h7F; psum=-300 -> 8'h80.
- out_bw=8 with ReLU; psum=1000 -> out_data=255. psum=255 -> 255. psum=0 -> 0.
- Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> out_data and out_addr stable, in_ready=0, count unchanged, proto_err=1. Then out_ready=1 -> single handshake; in_ready high the next cycle.
- addr_bw=2; 5 back-to-back groups with acc_len=0, treated as 1 -> addresses 0,1,2,3,0.
- Assert rst for 1 cycle during HOLD, and separately after 2 of 4 strobes in ACC -> next cycle out_valid=0, out_addr=0, in_ready=1, proto_err=0. A following 4-strobe group produces exactly one output.
